// File: rtl/imem_pkg.sv
// Shared types and helpers for the loadable instruction memory.
// Holds the sequencer state encoding, the NOP word and the fetch fault rule.
package imem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0000;

  // A fetch faults when it is not word aligned, or when it points past the array.
  // Callers zero-extend the PC to 64 bits.
  function automatic logic fault_check(input logic [63:0] pc, input int addr_w);
    logic misaligned;
    logic out_of_range;
    misaligned   = (pc[1:0] != 2'b00);
    out_of_range = ((pc >> (addr_w + 2)) != 64'd0);
    return misaligned || out_of_range;
  endfunction

endpackage

// File: rtl/imem_ram.sv
// Single-port word array with synchronous write and a registered read.
// Only the read register is reset; array contents stay undefined until swept.
module imem_ram #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/imem_loadable.sv
// Loadable instruction memory: zero-fill sweep after reset or on request,
// a program-loader write port, and a one-cycle-latency fetch port with fault flags.
module imem_loadable
  import imem_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [PC_W-1:0]   fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_fault,
  output logic              fault_sticky,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              clear_req,
  output logic              clear_busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] SWEEP_LAST = (ADDR_W + 1)'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W:0]   sweep_cnt;
  logic              in_run;
  logic              do_load;
  logic              fetch_acc;
  logic              fault_now;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;

  assign in_run      = (state == RUN);
  assign clear_busy  = (state == CLEAR);
  assign fetch_ready = in_run && !load_en;

  // clear_req outranks both the loader and the fetch port in the same cycle.
  assign do_load   = in_run && load_en && !clear_req;
  assign fetch_acc = fetch_req && fetch_ready && !clear_req;
  assign fault_now = fault_check(64'(fetch_addr), ADDR_W);

  always_comb begin
    ram_addr  = fetch_addr[ADDR_W+1:2];
    ram_we    = 1'b0;
    ram_wdata = load_data;
    if (state == CLEAR) begin
      ram_addr  = sweep_cnt[ADDR_W-1:0];
      ram_we    = 1'b1;
      ram_wdata = DATA_W'(NOP);
    end else if (do_load) begin
      ram_addr = load_addr;
      ram_we   = 1'b1;
    end
  end

  // Faulting fetches leave the read register untouched; the output mux forces zero.
  assign ram_re = fetch_acc && !fault_now;

  imem_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (ram_wdata),
    .re    (ram_re),
    .rdata (ram_rdata)
  );

  assign fetch_data = fetch_fault ? '0 : ram_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= CLEAR;
      sweep_cnt    <= '0;
      fetch_valid  <= 1'b0;
      fetch_fault  <= 1'b0;
      fault_sticky <= 1'b0;
    end else begin
      fetch_valid <= fetch_acc;
      if (fetch_acc) begin
        fetch_fault <= fault_now;
        if (fault_now) begin
          fault_sticky <= 1'b1;
        end
      end
      case (state)
        CLEAR: begin
          sweep_cnt <= sweep_cnt + 1'b1;
          if (sweep_cnt == SWEEP_LAST) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (clear_req) begin
            state        <= CLEAR;
            sweep_cnt    <= '0;
            fault_sticky <= 1'b0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loadable.sv
// Self-checking bench for imem_loadable: behavioural model plus directed literal checks
// and a randomized traffic phase.
module tb_imem_loadable;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int PC_W   = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              rst;
  logic              fetch_req;
  logic [PC_W-1:0]   fetch_addr;
  logic              fetch_ready;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_fault;
  logic              fault_sticky;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              clear_req;
  logic              clear_busy;

  int checks   = 0;
  int failures = 0;
  bit check_en = 0;

  imem_loadable #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .PC_W   (PC_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_ready  (fetch_ready),
    .fetch_valid  (fetch_valid),
    .fetch_data   (fetch_data),
    .fetch_fault  (fetch_fault),
    .fault_sticky (fault_sticky),
    .load_en      (load_en),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .clear_req    (clear_req),
    .clear_busy   (clear_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: sweep_left counts remaining zero-fill edges.
  logic [31:0] m_mem [DEPTH];
  int          m_left   = DEPTH;
  logic        m_valid  = 1'b0;
  logic [31:0] m_data   = '0;
  logic        m_fault  = 1'b0;
  logic        m_sticky = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left   = DEPTH;
      m_valid  = 1'b0;
      m_data   = '0;
      m_fault  = 1'b0;
      m_sticky = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (m_left > 0) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
        end
      end else if (clear_req) begin
        m_left   = DEPTH;
        m_sticky = 1'b0;
      end else if (load_en) begin
        m_mem[load_addr] = load_data;
      end else if (fetch_req) begin
        m_valid = 1'b1;
        if ((fetch_addr % 4) != 0 || fetch_addr >= 4 * DEPTH) begin
          m_fault  = 1'b1;
          m_data   = 32'h0;
          m_sticky = 1'b1;
        end else begin
          m_fault = 1'b0;
          m_data  = m_mem[fetch_addr / 4];
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic le, input logic [ADDR_W-1:0] la, input logic [31:0] ld,
                               input logic fr, input logic [31:0] fa, input logic cr);
    load_en    = le;
    load_addr  = la;
    load_data  = ld;
    fetch_req  = fr;
    fetch_addr = fa;
    clear_req  = cr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  // Single fetch with literal expectations, sampled just after the response edge.
  task automatic fetchExpect(input string name, input logic [31:0] pc, input logic [31:0] exp_data,
                             input logic exp_fault);
    applyStimulus(1'b0, '0, '0, 1'b1, pc, 1'b0);
    step();
    checkOutput({name, "_valid"}, 32'(fetch_valid), 32'd1);
    checkOutput({name, "_data"}, fetch_data, exp_data);
    checkOutput({name, "_fault"}, 32'(fetch_fault), 32'(exp_fault));
    idle();
  endtask

  task automatic waitSweep(input string name);
    int n;
    n = 0;
    while (!fetch_ready && n < 200) begin
      step();
      n++;
    end
    checkOutput(name, n, DEPTH);
  endtask

  // Compare process: the model is checked against the DUT on every falling edge.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("m_valid", 32'(fetch_valid), 32'(m_valid));
      checkOutput("m_data", fetch_data, m_data);
      checkOutput("m_fault", 32'(fetch_fault), 32'(m_fault));
      checkOutput("m_sticky", 32'(fault_sticky), 32'(m_sticky));
      checkOutput("m_busy", 32'(clear_busy), 32'(m_left > 0));
      checkOutput("m_ready", 32'(fetch_ready), 32'(m_left == 0 && !rst && !load_en));
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int r;
    logic [31:0] pc;
    rst = 1'b1;
    idle();
    step();
    step();
    check_en = 1;
    checkOutput("rst_busy", 32'(clear_busy), 32'd1);
    checkOutput("rst_ready", 32'(fetch_ready), 32'd0);
    checkOutput("rst_valid", 32'(fetch_valid), 32'd0);
    checkOutput("rst_data", fetch_data, 32'h0);
    checkOutput("rst_sticky", 32'(fault_sticky), 32'd0);

    rst = 1'b0;
    waitSweep("sweep_after_reset");
    fetchExpect("zero_3c", 32'h3C, 32'h0, 1'b0);

    applyStimulus(1'b1, 6'd0, 32'h2002_0005, 1'b0, '0, 1'b0);
    step();
    applyStimulus(1'b1, 6'd15, 32'hac47_0047, 1'b0, '0, 1'b0);
    step();
    applyStimulus(1'b0, '0, '0, 1'b1, 32'h0, 1'b0);
    step();
    checkOutput("b2b0_valid", 32'(fetch_valid), 32'd1);
    checkOutput("b2b0_data", fetch_data, 32'h2002_0005);
    applyStimulus(1'b0, '0, '0, 1'b1, 32'h3C, 1'b0);
    step();
    checkOutput("b2b1_valid", 32'(fetch_valid), 32'd1);
    checkOutput("b2b1_data", fetch_data, 32'hac47_0047);
    idle();
    step();
    checkOutput("idle_valid", 32'(fetch_valid), 32'd0);
    checkOutput("idle_hold", fetch_data, 32'hac47_0047);

    fetchExpect("misaligned", 32'h2, 32'h0, 1'b1);
    checkOutput("sticky_set", 32'(fault_sticky), 32'd1);
    fetchExpect("out_of_range", 32'h100, 32'h0, 1'b1);

    applyStimulus(1'b1, 6'd5, 32'h1234_5678, 1'b1, 32'h14, 1'b0);
    #1;
    checkOutput("load_blocks_ready", 32'(fetch_ready), 32'd0);
    step();
    checkOutput("load_no_valid", 32'(fetch_valid), 32'd0);
    fetchExpect("load_then_fetch", 32'h14, 32'h1234_5678, 1'b0);
    checkOutput("sticky_holds", 32'(fault_sticky), 32'd1);

    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
    step();
    checkOutput("clear_busy", 32'(clear_busy), 32'd1);
    checkOutput("clear_sticky", 32'(fault_sticky), 32'd0);
    n = 0;
    while (clear_busy && n < 200) begin
      applyStimulus(1'b1, 6'($urandom_range(0, DEPTH - 1)), $urandom, 1'b1, 32'h0, 1'($urandom_range(0, 1)));
      step();
      n++;
    end
    idle();
    checkOutput("clear_len", n, DEPTH);
    fetchExpect("cleared_w0", 32'h0, 32'h0, 1'b0);
    fetchExpect("cleared_w15", 32'h3C, 32'h0, 1'b0);
    fetchExpect("cleared_w5", 32'h14, 32'h0, 1'b0);

    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
    step();
    idle();
    for (int i = 0; i < 20; i++) step();
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", 32'(clear_busy), 32'd1);
    checkOutput("midrst_ready", 32'(fetch_ready), 32'd0);
    checkOutput("midrst_valid", 32'(fetch_valid), 32'd0);
    step();
    rst = 1'b0;
    waitSweep("sweep_after_midrst");

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      case ($urandom_range(0, 4))
        0:       pc = {$urandom_range(0, DEPTH - 1), 2'($urandom_range(1, 3))};
        1:       pc = $urandom;
        default: pc = {$urandom_range(0, DEPTH - 1), 2'b00};
      endcase
      applyStimulus(1'(r < 25), 6'($urandom_range(0, DEPTH - 1)), $urandom,
                    1'(r >= 15), pc, 1'(r == 99));
      step();
    end
    idle();
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
